// File: rtl/periph_demux_pkg.sv
// periph_demux_pkg: shared destination type, error payload and default address map
package periph_demux_pkg;

    // Sized for the largest supported target count (8) plus the internal ERR slot
    localparam int MAX_TARGETS = 8;
    typedef logic [$clog2(MAX_TARGETS+1)-1:0] dst_t;

    localparam logic [31:0] ERR_RDATA  = 32'hBADA_CCE5;
    localparam logic [31:0] EU_BASE    = 32'h1020_4000;
    localparam logic [31:0] EU_MASK    = 32'hFFFF_FC00;
    localparam logic [31:0] MCHAN_BASE = 32'h1020_4400;
    localparam logic [31:0] MCHAN_MASK = 32'hFFFF_FC00;

endpackage

// File: rtl/periph_demux_multi_err_slave.sv
// periph_err_slave: answers every unmapped access with an error one cycle after its grant
module periph_err_slave
    import periph_demux_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  gnt_i,
    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_rdata_o,
    output logic                  r_opc_o
);

    localparam int PW = $clog2(MAX_OUTSTANDING+1);

    logic [PW-1:0] pending_q, pending_d;

    assign r_valid_o = pending_q != '0;
    assign r_rdata_o = r_valid_o ? DATA_WIDTH'(ERR_RDATA) : '0;
    assign r_opc_o   = r_valid_o;

    // each grant becomes pending for one cycle and is retired by its response
    always_comb begin
        pending_d = pending_q + PW'(gnt_i) - PW'(r_valid_o);
    end

    // pending count, cleared asynchronously
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) pending_q <= '0;
        else       pending_q <= pending_d;
    end

endmodule

// File: rtl/periph_demux_multi.sv
// periph_demux_multi: address-mapped core-to-peripheral demux with in-order responses and error slave
module periph_demux_multi
    import periph_demux_pkg::*;
#(
    parameter int NUM_TARGETS     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH/8,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] MAP_BASE [NUM_TARGETS] = '{EU_BASE, MCHAN_BASE},
    parameter logic [ADDR_WIDTH-1:0] MAP_MASK [NUM_TARGETS] = '{EU_MASK, MCHAN_MASK}
) (
    input  logic                                  clk,
    input  logic                                  rst_i,
    input  logic                                  data_req_i,
    input  logic [ADDR_WIDTH-1:0]                 data_add_i,
    input  logic                                  data_wen_i,
    input  logic [DATA_WIDTH-1:0]                 data_wdata_i,
    input  logic [BE_WIDTH-1:0]                   data_be_i,
    output logic                                  data_gnt_o,
    output logic                                  data_r_valid_o,
    output logic [DATA_WIDTH-1:0]                 data_r_rdata_o,
    output logic                                  data_r_opc_o,
    output logic [NUM_TARGETS-1:0]                tgt_req_o,
    output logic [ADDR_WIDTH-1:0]                 tgt_add_o,
    output logic                                  tgt_wen_o,
    output logic [DATA_WIDTH-1:0]                 tgt_wdata_o,
    output logic [BE_WIDTH-1:0]                   tgt_be_o,
    input  logic [NUM_TARGETS-1:0]                tgt_gnt_i,
    input  logic [NUM_TARGETS-1:0]                tgt_r_valid_i,
    input  logic [NUM_TARGETS-1:0]                tgt_r_opc_i,
    input  logic [NUM_TARGETS-1:0][DATA_WIDTH-1:0] tgt_r_rdata_i
);

    localparam int            CW      = $clog2(MAX_OUTSTANDING+1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
    localparam dst_t          ERR_DST = dst_t'(NUM_TARGETS);

    dst_t                   dst, cur_dst_q, cur_dst_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   issue, sel_valid, sel_opc, err_valid, err_opc;
    logic [DATA_WIDTH-1:0]  sel_rdata, err_rdata;
    logic [NUM_TARGETS-1:0] rsp_mask;

    assign tgt_add_o   = data_add_i;
    assign tgt_wen_o   = data_wen_i;
    assign tgt_wdata_o = data_wdata_i;
    assign tgt_be_o    = data_be_i;

    // address decode: lowest matching index wins, ERR_DST when nothing matches
    always_comb begin
        dst = ERR_DST;
        for (int i = NUM_TARGETS-1; i >= 0; i--)
            if ((data_add_i & MAP_MASK[i]) == (MAP_BASE[i] & MAP_MASK[i])) dst = dst_t'(i);
    end

    // issue only towards the destination already in flight, so responses cannot reorder
    always_comb begin
        issue     = data_req_i && cnt_q < CNT_MAX && (cnt_q == '0 || dst == cur_dst_q);
        tgt_req_o = '0;
        for (int i = 0; i < NUM_TARGETS; i++) tgt_req_o[i] = issue && dst == dst_t'(i);
        data_gnt_o = issue && (dst == ERR_DST || |(tgt_req_o & tgt_gnt_i));
    end

    // response mux steered by the registered destination; silent while nothing is outstanding
    always_comb begin
        sel_valid = err_valid;
        sel_rdata = err_rdata;
        sel_opc   = err_opc;
        rsp_mask  = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            rsp_mask[i] = cnt_q != '0 && cur_dst_q == dst_t'(i);
            if (cur_dst_q == dst_t'(i)) begin
                sel_valid = tgt_r_valid_i[i];
                sel_rdata = tgt_r_rdata_i[i];
                sel_opc   = tgt_r_opc_i[i];
            end
        end
        data_r_valid_o = cnt_q != '0 && sel_valid;
        data_r_rdata_o = cnt_q != '0 ? sel_rdata : '0;
        data_r_opc_o   = cnt_q != '0 && sel_opc;
    end

    // outstanding bookkeeping: grants count in, responses count out
    always_comb begin
        cnt_d     = cnt_q + CW'(data_gnt_o) - CW'(data_r_valid_o);
        cur_dst_d = data_gnt_o ? dst : cur_dst_q;
    end

    // state registers, cleared asynchronously so a reset drops everything in flight
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            cur_dst_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            cur_dst_q <= cur_dst_d;
        end
    end

    periph_err_slave #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .DATA_WIDTH      (DATA_WIDTH)
    ) u_err (
        .clk       (clk),
        .rst_i     (rst_i),
        .gnt_i     (data_gnt_o && dst == ERR_DST),
        .r_valid_o (err_valid),
        .r_rdata_o (err_rdata),
        .r_opc_o   (err_opc)
    );

    // target responses are only legal from the destination currently in flight
    a_rsp_src: assert property (@(posedge clk) disable iff (rst_i) (tgt_r_valid_i & ~rsp_mask) == '0);

endmodule

// File: tb/tb_periph_demux_multi.sv
// tb_periph_demux_multi: directed stimulus checked against a queue-based model of the demux
module tb_periph_demux_multi;

    localparam int NT   = 2;
    localparam int MAXO = 2;

    logic                clk = 0;
    logic                rst_i = 1;
    logic                data_req_i = 0;
    logic [31:0]         data_add_i = '0;
    logic                data_wen_i = 0;
    logic [31:0]         data_wdata_i = '0;
    logic [3:0]          data_be_i = '0;
    logic                data_gnt_o, data_r_valid_o, data_r_opc_o, tgt_wen_o;
    logic [31:0]         data_r_rdata_o, tgt_add_o, tgt_wdata_o;
    logic [3:0]          tgt_be_o;
    logic [NT-1:0]       tgt_req_o;
    logic [NT-1:0]       tgt_gnt_i = '0, tgt_r_valid_i = '0, tgt_r_opc_i = '0;
    logic [NT-1:0][31:0] tgt_r_rdata_i = '0;

    int errors = 0;
    int checks = 0;

    logic [31:0] map_base [NT] = '{32'h1020_4000, 32'h1020_4400};
    logic [31:0] map_mask [NT] = '{32'hFFFF_FC00, 32'hFFFF_FC00};
    int pend[$];
    bit err_due = 0;

    always #5 clk = ~clk;

    periph_demux_multi dut (
        .clk            (clk),
        .rst_i          (rst_i),
        .data_req_i     (data_req_i),
        .data_add_i     (data_add_i),
        .data_wen_i     (data_wen_i),
        .data_wdata_i   (data_wdata_i),
        .data_be_i      (data_be_i),
        .data_gnt_o     (data_gnt_o),
        .data_r_valid_o (data_r_valid_o),
        .data_r_rdata_o (data_r_rdata_o),
        .data_r_opc_o   (data_r_opc_o),
        .tgt_req_o      (tgt_req_o),
        .tgt_add_o      (tgt_add_o),
        .tgt_wen_o      (tgt_wen_o),
        .tgt_wdata_o    (tgt_wdata_o),
        .tgt_be_o       (tgt_be_o),
        .tgt_gnt_i      (tgt_gnt_i),
        .tgt_r_valid_i  (tgt_r_valid_i),
        .tgt_r_opc_i    (tgt_r_opc_i),
        .tgt_r_rdata_i  (tgt_r_rdata_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NT; i++)
            if ((a & map_mask[i]) == (map_base[i] & map_mask[i])) return i;
        return NT;
    endfunction

    // model: a queue of destinations in flight; responses come from the oldest one
    always @(negedge clk) begin
        int d;
        bit go, egnt, ev, eop;
        logic [31:0] erd;
        logic [NT-1:0] ereq;
        if (rst_i) begin
            pend.delete();
            err_due = 0;
        end else begin
            d    = decode(data_add_i);
            go   = data_req_i && pend.size() < MAXO && (pend.size() == 0 || pend[0] == d);
            ereq = '0;
            if (go && d < NT) ereq[d] = 1'b1;
            egnt = go && (d == NT ? 1'b1 : tgt_gnt_i[d]);
            ev = 0; erd = '0; eop = 0;
            if (pend.size() > 0) begin
                if (pend[0] == NT) begin
                    ev = err_due; erd = 32'hBADA_CCE5; eop = 1;
                end else begin
                    ev = tgt_r_valid_i[pend[0]]; erd = tgt_r_rdata_i[pend[0]]; eop = tgt_r_opc_i[pend[0]];
                end
            end
            chk("m_tgt_req", 32'(tgt_req_o), 32'(ereq));
            chk("m_gnt", 32'(data_gnt_o), 32'(egnt));
            chk("m_r_valid", 32'(data_r_valid_o), 32'(ev));
            if (ev) begin
                chk("m_rdata", data_r_rdata_o, erd);
                chk("m_opc", 32'(data_r_opc_o), 32'(eop));
            end
            chk("m_add", tgt_add_o, data_add_i);
            chk("m_wdata", tgt_wdata_o, data_wdata_i);
            chk("m_wen_be", {27'd0, tgt_wen_o, tgt_be_o}, {27'd0, data_wen_i, data_be_i});
            if (ev) void'(pend.pop_front());
            if (egnt) pend.push_back(d);
            err_due = egnt && d == NT;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        data_req_i = 0; tgt_gnt_i = '0; tgt_r_valid_i = '0; tgt_r_opc_i = '0;
    endtask

    task automatic req(input logic [31:0] a, input logic w, input logic [NT-1:0] g);
        data_req_i = 1; data_add_i = a; data_wen_i = w; tgt_gnt_i = g;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc(); cyc();
        @(negedge clk);
        chk("rst_valid", 32'(data_r_valid_o), 0);
        chk("rst_gnt", 32'(data_gnt_o), 0);
        chk("rst_rdata", data_r_rdata_o, 0);
        cyc();
        rst_i = 0;

        // EU read, same-cycle grant, response a cycle later
        req(32'h1020_4000, 1, 2'b01);
        @(negedge clk); chk("t1_gnt", 32'(data_gnt_o), 1); chk("t1_req", 32'(tgt_req_o), 32'h1);
        cyc(); idle(); tgt_r_valid_i = 2'b01; tgt_r_rdata_i[0] = 32'hCAFE_0001;
        @(negedge clk); chk("t1_valid", 32'(data_r_valid_o), 1); chk("t1_rdata", data_r_rdata_o, 32'hCAFE_0001); chk("t1_opc", 32'(data_r_opc_o), 0);
        cyc(); idle();

        // MCHAN write with grant withheld for 3 cycles
        data_wdata_i = 32'h1234_5678; data_be_i = 4'hF;
        for (int k = 0; k < 3; k++) begin
            req(32'h1020_4404, 0, 2'b00);
            @(negedge clk); chk("t2_gnt_low", 32'(data_gnt_o), 0); chk("t2_req", 32'(tgt_req_o), 32'h2); chk("t2_wdata", tgt_wdata_o, 32'h1234_5678);
            cyc();
        end
        tgt_gnt_i = 2'b10;
        @(negedge clk); chk("t2_gnt", 32'(data_gnt_o), 1);
        cyc(); idle(); tgt_r_valid_i = 2'b10; tgt_r_rdata_i[1] = '0;
        cyc(); idle();

        // unmapped access answered by the error slave, then two back to back
        req(32'h1020_5000, 1, 2'b11);
        @(negedge clk); chk("t3_gnt", 32'(data_gnt_o), 1); chk("t3_req", 32'(tgt_req_o), 0);
        cyc(); idle();
        @(negedge clk); chk("t3_valid", 32'(data_r_valid_o), 1); chk("t3_opc", 32'(data_r_opc_o), 1); chk("t3_rdata", data_r_rdata_o, 32'hBADA_CCE5);
        cyc();
        req(32'h1020_5000, 1, 2'b00); cyc();
        @(negedge clk); chk("t3_b2b_gnt", 32'(data_gnt_o), 1); chk("t3_b2b_valid", 32'(data_r_valid_o), 1);
        cyc(); idle(); cyc(); cyc();

        // two EU in flight block a MCHAN request until both drain
        req(32'h1020_4000, 1, 2'b01); cyc();
        req(32'h1020_4004, 1, 2'b01); cyc();
        req(32'h1020_4400, 1, 2'b11);
        @(negedge clk); chk("t4_block_gnt", 32'(data_gnt_o), 0); chk("t4_block_req", 32'(tgt_req_o), 0);
        cyc(); tgt_r_valid_i = 2'b01; tgt_r_rdata_i[0] = 32'hAAAA_0001;
        @(negedge clk); chk("t4_gnt_r1", 32'(data_gnt_o), 0);
        cyc(); tgt_r_rdata_i[0] = 32'hAAAA_0002;
        @(negedge clk); chk("t4_gnt_r2", 32'(data_gnt_o), 0); chk("t4_rdata2", data_r_rdata_o, 32'hAAAA_0002);
        cyc(); tgt_r_valid_i = '0;
        @(negedge clk); chk("t4_gnt", 32'(data_gnt_o), 1); chk("t4_req", 32'(tgt_req_o), 32'h2);
        cyc(); idle(); tgt_r_valid_i = 2'b10;
        cyc(); idle();

        // full: a same-cycle response does not unblock issue
        req(32'h1020_4000, 1, 2'b01); cyc();
        req(32'h1020_4004, 1, 2'b01); cyc();
        req(32'h1020_4008, 1, 2'b01); tgt_r_valid_i = 2'b01; tgt_r_rdata_i[0] = 32'hBBBB_0001;
        @(negedge clk); chk("t4b_full_gnt", 32'(data_gnt_o), 0);
        cyc(); tgt_r_valid_i = '0;
        @(negedge clk); chk("t4b_resume_gnt", 32'(data_gnt_o), 1);
        cyc(); idle(); tgt_r_valid_i = 2'b01; tgt_r_rdata_i[0] = 32'hBBBB_0002;
        cyc(); tgt_r_rdata_i[0] = 32'hBBBB_0003;
        cyc(); idle();

        // 8 EU accesses with grant and response overlapping
        req(32'h1020_4000, 1, 2'b01); cyc();
        for (int k = 1; k < 8; k++) begin
            req(32'h1020_4000 + 32'(k * 4), 1, 2'b01); tgt_r_valid_i = 2'b01; tgt_r_rdata_i[0] = 32'hD000_0000 + 32'(k);
            @(negedge clk); chk("t5_gnt", 32'(data_gnt_o), 1); chk("t5_rdata", data_r_rdata_o, 32'hD000_0000 + 32'(k));
            cyc();
        end
        idle(); tgt_r_valid_i = 2'b01; tgt_r_rdata_i[0] = 32'hD000_0008;
        @(negedge clk); chk("t5_last", data_r_rdata_o, 32'hD000_0008);
        cyc(); idle();

        // asynchronous reset with two outstanding
        req(32'h1020_4000, 1, 2'b01); cyc();
        req(32'h1020_4004, 1, 2'b01); cyc();
        idle(); tgt_r_valid_i = 2'b01; tgt_r_rdata_i[0] = 32'h0000_1234;
        @(negedge clk); chk("t6_pre_valid", 32'(data_r_valid_o), 1);
        #2 rst_i = 1;
        #1;
        chk("t6_async_valid", 32'(data_r_valid_o), 0);
        chk("t6_async_rdata", data_r_rdata_o, 0);
        chk("t6_async_gnt", 32'(data_gnt_o), 0);
        chk("t6_async_req", 32'(tgt_req_o), 0);
        cyc(); idle(); cyc();
        rst_i = 0;
        req(32'h1020_4400, 1, 2'b10);
        @(negedge clk); chk("t6_mchan_gnt", 32'(data_gnt_o), 1); chk("t6_mchan_req", 32'(tgt_req_o), 32'h2);
        cyc(); idle(); tgt_r_valid_i = 2'b10; tgt_r_rdata_i[1] = 32'h5555_0001;
        @(negedge clk); chk("t6_mchan_rdata", data_r_rdata_o, 32'h5555_0001);
        cyc(); idle(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
